// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a 4-pixel ramp-ADC sensor array: erase, expose, ramp conversion
// with a free-running code on the shared counter bus, then sequential per-pixel readout.
module pixel_array_ctrl #(
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 255,
    parameter int READ_CYCLES    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic [3:0] read,
    output logic [7:0] counter_out,
    output logic       counter_oe,
    input  logic [7:0] counter_in,
    output logic       busy,
    output logic [7:0] pixel_data,
    output logic [1:0] pixel_idx,
    output logic       pixel_valid,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    localparam logic [15:0] ERASE_LAST   = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] EXPOSE_LAST  = 16'(EXPOSE_CYCLES - 1);
    localparam logic [15:0] CONVERT_LAST = 16'(CONVERT_CYCLES - 1);
    localparam logic [15:0] READ_LAST    = 16'(READ_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [15:0] timer_reg, timer_next;
    logic [1:0]  slot_reg, slot_next;

    logic       erase_next, expose_next, convert_next, busy_next;
    logic [3:0] read_next;
    logic [7:0] counter_out_next;
    logic       counter_oe_next;
    logic [7:0] pixel_data_next;
    logic [1:0] pixel_idx_next;
    logic       pixel_valid_next, frame_done_next;

    // timer_reg counts cycles spent in the current phase (or read slot), starting at 0
    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg + 16'd1;
        slot_next        = slot_reg;
        pixel_data_next  = pixel_data;
        pixel_idx_next   = pixel_idx;
        pixel_valid_next = 1'b0;
        frame_done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                timer_next = 16'd0;
                slot_next  = 2'd0;
                if (start) begin
                    state_next = S_ERASE;
                end
            end
            S_ERASE: begin
                if (timer_reg == ERASE_LAST) begin
                    state_next = S_EXPOSE;
                    timer_next = 16'd0;
                end
            end
            S_EXPOSE: begin
                if (timer_reg == EXPOSE_LAST) begin
                    state_next = S_CONVERT;
                    timer_next = 16'd0;
                end
            end
            S_CONVERT: begin
                if (timer_reg == CONVERT_LAST) begin
                    state_next = S_READ;
                    timer_next = 16'd0;
                    slot_next  = 2'd0;
                end
            end
            S_READ: begin
                // The pixel has driven its latched code for the whole slot; sample at slot end
                if (timer_reg == READ_LAST) begin
                    timer_next       = 16'd0;
                    pixel_data_next  = counter_in;
                    pixel_idx_next   = slot_reg;
                    pixel_valid_next = 1'b1;
                    if (slot_reg == 2'd3) begin
                        state_next      = S_IDLE;
                        frame_done_next = 1'b1;
                    end else begin
                        slot_next = slot_reg + 2'd1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = 16'd0;
                slot_next  = 2'd0;
            end
        endcase
    end

    // Controls are decoded from the upcoming state so every output comes straight from a flop
    assign erase_next       = (state_next == S_ERASE);
    assign expose_next      = (state_next == S_EXPOSE);
    assign convert_next     = (state_next == S_CONVERT);
    assign counter_oe_next  = (state_next == S_CONVERT);
    assign counter_out_next = (state_next == S_CONVERT) ? timer_next[7:0] : 8'd0;
    assign busy_next        = (state_next != S_IDLE);

    for (genvar gi = 0; gi < 4; gi++) begin : g_read
        assign read_next[gi] = (state_next == S_READ) && (slot_next == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            timer_reg   <= 16'd0;
            slot_reg    <= 2'd0;
            erase       <= 1'b0;
            expose      <= 1'b0;
            convert     <= 1'b0;
            read        <= 4'd0;
            counter_out <= 8'd0;
            counter_oe  <= 1'b0;
            busy        <= 1'b0;
            pixel_data  <= 8'd0;
            pixel_idx   <= 2'd0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            slot_reg    <= slot_next;
            erase       <= erase_next;
            expose      <= expose_next;
            convert     <= convert_next;
            read        <= read_next;
            counter_out <= counter_out_next;
            counter_oe  <= counter_oe_next;
            busy        <= busy_next;
            pixel_data  <= pixel_data_next;
            pixel_idx   <= pixel_idx_next;
            pixel_valid <= pixel_valid_next;
            frame_done  <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: two instances (default timing, and a short frame with a
// 256-cycle conversion) checked every cycle against a frame-time reference model.
module tb_pixel_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_v, start_v;
    logic [1:0]      erase_v, expose_v, convert_v, oe_v, busy_v, pv_v, fd_v;
    logic [1:0][3:0] read_v;
    logic [1:0][7:0] cout_v, cin_v, pd_v;
    logic [1:0][1:0] pi_v;

    pixel_array_ctrl dut_a (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]),
        .erase(erase_v[0]), .expose(expose_v[0]), .convert(convert_v[0]), .read(read_v[0]),
        .counter_out(cout_v[0]), .counter_oe(oe_v[0]), .counter_in(cin_v[0]), .busy(busy_v[0]),
        .pixel_data(pd_v[0]), .pixel_idx(pi_v[0]), .pixel_valid(pv_v[0]), .frame_done(fd_v[0])
    );

    pixel_array_ctrl #(
        .ERASE_CYCLES(2), .EXPOSE_CYCLES(3), .CONVERT_CYCLES(256), .READ_CYCLES(2)
    ) dut_b (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]),
        .erase(erase_v[1]), .expose(expose_v[1]), .convert(convert_v[1]), .read(read_v[1]),
        .counter_out(cout_v[1]), .counter_oe(oe_v[1]), .counter_in(cin_v[1]), .busy(busy_v[1]),
        .pixel_data(pd_v[1]), .pixel_idx(pi_v[1]), .pixel_valid(pv_v[1]), .frame_done(fd_v[1])
    );

    int pe [2] = '{5, 2};
    int px [2] = '{255, 3};
    int pc [2] = '{255, 256};
    int pr [2] = '{5, 2};

    int         t [2];          // cycle index within the current frame, -1 when idle
    logic [7:0] tgt [2][4];     // code at which each pixel's comparator trips
    logic [7:0] lat [2][4];     // code actually captured by each pixel from the bus
    logic [7:0] exp_pd [2];
    logic [1:0] exp_pi [2];
    bit         fixed_codes;
    int         n_done_a;
    int         n_chk, n_pass;

    // Pixel array model: the selected pixel drives its captured code while the bus is released
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            cin_v[d] = oe_v[d] ? cout_v[d] : 8'h00;
            for (int i = 0; i < 4; i++)
                if (!oe_v[d] && read_v[d][i]) cin_v[d] = lat[d][i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    function automatic int flen(input int d);
        return pe[d] + px[d] + pc[d] + 4 * pr[d];
    endfunction

    // Called before each edge: applies the inputs the edge is about to sample to the model
    task automatic advance(input int d);
        int L, k;
        L = flen(d);
        for (int i = 0; i < 4; i++)
            if (oe_v[d] && cout_v[d] == tgt[d][i]) lat[d][i] = cout_v[d];
        if (rst_v[d]) begin
            t[d] = -1;
            exp_pd[d] = 8'd0;
            exp_pi[d] = 2'd0;
            return;
        end
        if (t[d] < 0 || t[d] >= L) begin
            if (start_v[d]) begin
                t[d] = 0;
                for (int i = 0; i < 4; i++) begin
                    lat[d][i] = 8'd0;
                    tgt[d][i] = fixed_codes ? 8'(51 * (i + 1)) : 8'($urandom_range(0, pc[d] - 1));
                end
            end else begin
                t[d] = -1;
            end
        end else begin
            t[d]++;
        end
        k = t[d] - (pe[d] + px[d] + pc[d]);
        if (t[d] >= 0 && k >= pr[d] && k <= 4 * pr[d] && k % pr[d] == 0) begin
            exp_pi[d] = 2'(k / pr[d] - 1);
            exp_pd[d] = tgt[d][k / pr[d] - 1];
        end
    endtask

    task automatic check(input int d);
        int L, b, k;
        logic in_f, e_er, e_ex, e_cv, e_pv, e_fd;
        logic [3:0] e_rd;
        logic [7:0] e_cout;
        L = flen(d);
        b = pe[d] + px[d] + pc[d];
        k = t[d] - b;
        in_f   = (t[d] >= 0 && t[d] < L);
        e_er   = in_f && t[d] < pe[d];
        e_ex   = in_f && t[d] >= pe[d] && t[d] < pe[d] + px[d];
        e_cv   = in_f && t[d] >= pe[d] + px[d] && t[d] < b;
        e_rd   = (in_f && t[d] >= b) ? 4'(1 << (k / pr[d])) : 4'd0;
        e_cout = e_cv ? 8'(t[d] - pe[d] - px[d]) : 8'd0;
        e_pv   = (t[d] >= 0 && k >= pr[d] && k <= 4 * pr[d] && k % pr[d] == 0);
        e_fd   = (t[d] == L);
        chk($sformatf("ctrl%0d", d),
            {23'd0, erase_v[d], expose_v[d], convert_v[d], read_v[d], oe_v[d], busy_v[d]},
            {23'd0, e_er, e_ex, e_cv, e_rd, e_cv, in_f});
        chk($sformatf("cout%0d", d), {24'd0, cout_v[d]}, {24'd0, e_cout});
        chk($sformatf("strobe%0d", d), {30'd0, pv_v[d], fd_v[d]}, {30'd0, e_pv, e_fd});
        chk($sformatf("pixel%0d", d), {22'd0, pi_v[d], pd_v[d]}, {22'd0, exp_pi[d], exp_pd[d]});
        if (d == 0 && fd_v[0] === 1'b1) n_done_a++;
    endtask

    task automatic cyc();
        for (int d = 0; d < 2; d++) advance(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check(d);
    endtask

    initial begin
        bit found;
        n_chk = 0;
        n_pass = 0;
        n_done_a = 0;
        fixed_codes = 1'b1;
        for (int d = 0; d < 2; d++) begin
            t[d] = -1;
            exp_pd[d] = 8'd0;
            exp_pi[d] = 2'd0;
            for (int i = 0; i < 4; i++) begin
                tgt[d][i] = 8'd0;
                lat[d][i] = 8'd0;
            end
        end

        // Reset with start held, then quiet idle
        rst_v = 2'b11;
        start_v = 2'b11;
        repeat (3) cyc();
        rst_v = 2'b00;
        start_v = 2'b00;
        repeat (20) cyc();

        // Nominal frame with codes 51/102/153/204; extra starts mid-EXPOSE and mid-READ of A
        start_v = 2'b11;
        cyc();
        for (int i = 1; i < 560; i++) begin
            start_v = (i == 100 || i == 520) ? 2'b11 : 2'b00;
            cyc();
        end
        chk("frames_a", n_done_a, 1);

        // Back-to-back frames with start held high
        start_v = 2'b11;
        repeat (3 * 536 + 5) cyc();
        start_v = 2'b00;
        repeat (560) cyc();

        // Abort A in the middle of conversion, then run a clean frame
        fixed_codes = 1'b0;
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            cyc();
            if (convert_v[0] === 1'b1 && cout_v[0] === 8'd100) found = 1'b1;
        end
        chk("reach_code100", {31'd0, found}, 32'd1);
        rst_v[0] = 1'b1;
        cyc();
        rst_v[0] = 1'b0;
        repeat (5) cyc();
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        repeat (560) cyc();

        // Randomized start requests with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                start_v[d] = ($urandom_range(0, 7) == 0);
                rst_v[d]   = ($urandom_range(0, 599) == 0);
            end
            cyc();
        end
        rst_v = 2'b00;
        start_v = 2'b00;
        repeat (600) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
Frame sequencer for the 4-pixel sensor array. It generates the ERASE, EXPOSE, CONVERT (ramp enable) and READ1..READ4 controls. During conversion it drives the shared 8-bit counter bus with a free-running code. During readout it releases the bus, samples each pixel's latched code and presents it as a (pixel_idx, pixel_data, pixel_valid) stream to downstream logic.

Parameters:
ERASE_CYCLES, 5, cycles ERASE held high (1..65535)
EXPOSE_CYCLES, 255, cycles EXPOSE held high (1..65535)
CONVERT_CYCLES, 255, cycles of conversion; counter counts 0..CONVERT_CYCLES-1 (1..256)
READ_CYCLES, 5, cycles each READn is held high (2..65535)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request one frame; sampled only in IDLE
erase  output  1  pixel ERASE control
expose  output  1  pixel EXPOSE control
convert  output  1  ramp/comparator enable; high for the whole conversion window
read  output  4  one-hot READ1..READ4 (bit0 = READ1)
counter_out  output  8  code driven onto the shared COUNTER bus
counter_oe  output  1  tri-state enable for counter_out (top level drives COUNTER = oe ? counter_out : 'z)
counter_in  input  8  COUNTER bus value as seen by the controller
busy  output  1  high whenever state != IDLE
pixel_data  output  8  sampled pixel code
pixel_idx  output  2  pixel index (0..3) for pixel_data
pixel_valid  output  1  one-cycle strobe qualifying pixel_data/pixel_idx
frame_done  output  1  one-cycle strobe after the last pixel is sampled

Behaviour:
- All outputs are registered. Reset value of every output is 0; state = IDLE; internal 16-bit timer = 0; slot index = 0.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ -> IDLE.
- IDLE: all controls are 0. If start = 1 at a rising edge, the FSM enters ERASE at that edge, so erase = 1 in the next cycle.
- ERASE: erase = 1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose = 1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
- CONVERT:
  - convert = 1 and counter_oe = 1 for exactly CONVERT_CYCLES cycles.
  - counter_out = 0 in the first cycle and increments by 1 each cycle. The final value is CONVERT_CYCLES-1; the counter never wraps.
  - On exit, counter_out returns to 0 and counter_oe to 0 in the same cycle.
- READ: four slots, i = 0..3 in order.
  - In slot i, read = (1 << i) for READ_CYCLES cycles, and counter_oe = 0.
  - At the edge ending the last cycle of slot i: pixel_data <= counter_in and pixel_idx <= i. pixel_valid = 1 for the following cycle only.
  - After slot 3, the FSM returns to IDLE. frame_done = 1 in the same cycle as pixel_valid for idx 3.
- Mutual exclusion: at most one of erase, expose, convert or any read bit is high in any cycle. counter_oe = 1 only while convert = 1.
- Transitions between phases have no gap cycle: the next phase's control rises in the cycle after the previous one falls.
- start while busy is ignored (not queued). If start is still high in the IDLE cycle after frame_done, a new frame starts (back-to-back frames).
- busy rises in the first ERASE cycle and falls in the first IDLE cycle.
- Frame length is ERASE_CYCLES + EXPOSE_CYCLES + CONVERT_CYCLES + 4*READ_CYCLES cycles.
- Reset asserted in any state: at the next edge all outputs are 0 and the FSM is in IDLE. No pixel_valid or frame_done is emitted for an aborted frame.
- pixel_data and pixel_idx hold their last values between strobes and are only meaningful while pixel_valid = 1.

Test Plan:
- Reset/idle: hold reset 3 cycles with start = 1, release with start = 0 -> all outputs 0, busy = 0 for 20 cycles.
- Nominal frame, defaults; pixels latch 51/102/153/204 (bench models the array on counter_in):
  - erase high 5 cycles, expose 255, convert 255 with counter_out 0..254, then read = 0001, 0010, 0100, 1000 for 5 cycles each.
  - pixel_valid pulses 4 times with (idx, data) = (0,51), (1,102), (2,153), (3,204).
  - frame_done coincides with the idx 3 pulse; busy high for exactly 535 cycles.
- Conversion boundary, CONVERT_CYCLES = 256 -> counter_out reaches 255 in the last convert cycle with no wrap to 0 while counter_oe = 1. Then counter_oe = 0 and counter_out = 0.
- Start while busy: pulse start mid-EXPOSE and mid-READ -> no effect; exactly one frame, one frame_done.
- Back-to-back: hold start = 1 continuously -> the second frame's erase rises 1 cycle after frame_done, and every frame is identical.
- Reset mid-CONVERT at counter_out = 100 -> next cycle all outputs 0 and IDLE. No pixel_valid occurs. A following start produces a clean, complete frame.
